// File: rtl/rect_draw_engine_pkg.sv
// Shared constants for the rectangle rasteriser: draw modes and default
// colour/screen geometry.
package rect_draw_engine_pkg;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  localparam int COLOR_W_DEF  = 3;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

endpackage

// File: rtl/rect_draw_engine_scan.sv
// Column-major scan position generator (row inner, column outer); in outline
// mode interior columns jump straight from the top row to the bottom row.
module rect_scan_counter
  import rect_draw_engine_pkg::*;
#(
  parameter int SIZE_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [SIZE_W-1:0] w,
  input  logic [SIZE_W-1:0] h,
  input  logic              mode,
  output logic [SIZE_W-1:0] col,
  output logic [SIZE_W-1:0] row,
  output logic              last
);

  logic last_row;
  logic last_col;
  logic edge_col;
  logic skip_to_bottom;

  assign last_row       = (row == h - SIZE_W'(1));
  assign last_col       = (col == w - SIZE_W'(1));
  assign edge_col       = (col == '0) || last_col;
  assign last           = last_row && last_col;
  assign skip_to_bottom = (mode == MODE_OUTLINE) && !edge_col;

  // The position holds on the final advance; the next request clears it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance && !last) begin
      if (last_row) begin
        row <= '0;
        col <= col + SIZE_W'(1);
      end else if (skip_to_bottom) begin
        row <= h - SIZE_W'(1);
      end else begin
        row <= row + SIZE_W'(1);
      end
    end
  end

endmodule

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: accepts one request, streams clipped pixels with
// back-pressure, then pulses done.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// DRAW  | visiting positions, one per accepted or clipped cycle
// DONE  | one-cycle completion pulse
module rect_draw_engine
  import rect_draw_engine_pkg::*;
#(
  parameter int COORD_W  = 10,
  parameter int SIZE_W   = 6,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  input  logic [SIZE_W-1:0]  req_w,
  input  logic [SIZE_W-1:0]  req_h,
  input  logic [COLOR_W-1:0] req_color,
  input  logic               req_mode,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic [SIZE_W-1:0]  w_q;
  logic [SIZE_W-1:0]  h_q;
  logic [COLOR_W-1:0] color_q;
  logic               mode_q;

  logic [SIZE_W-1:0]  col;
  logic [SIZE_W-1:0]  row;
  logic               last;
  logic               accept;
  logic               in_draw;
  logic               clipped;
  logic               advance;
  logic [COORD_W:0]   sum_x;
  logic [COORD_W:0]   sum_y;

  assign accept  = req_valid && (state == ST_IDLE);
  assign in_draw = (state == ST_DRAW);

  // One extra bit so wrap-around past the coordinate range is clipped too.
  assign sum_x   = {1'b0, x0} + {{(COORD_W + 1 - SIZE_W){1'b0}}, col};
  assign sum_y   = {1'b0, y0} + {{(COORD_W + 1 - SIZE_W){1'b0}}, row};
  assign clipped = sum_x[COORD_W] || (sum_x >= (COORD_W + 1)'(SCREEN_W)) ||
                   sum_y[COORD_W] || (sum_y >= (COORD_W + 1)'(SCREEN_H));
  assign advance = in_draw && (clipped || pix_ready);

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign pix_valid = in_draw && !clipped;
  assign pix_x     = sum_x[COORD_W-1:0];
  assign pix_y     = sum_y[COORD_W-1:0];
  assign pix_color = color_q;

  rect_scan_counter #(
    .SIZE_W (SIZE_W)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .advance (advance),
    .w       (w_q),
    .h       (h_q),
    .mode    (mode_q),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      x0      <= '0;
      y0      <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      mode_q  <= MODE_FILL;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            x0      <= req_x;
            y0      <= req_y;
            w_q     <= req_w;
            h_q     <= req_h;
            color_q <= req_color;
            mode_q  <= req_mode;
            state   <= ((req_w == '0) || (req_h == '0)) ? ST_DONE : ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (advance && last) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_draw_engine.sv
// Self-checking bench for rect_draw_engine: directed scenarios plus random
// requests checked against a loop-based raster model.
module tb_rect_draw_engine;
  import rect_draw_engine_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_x, req_y;
  logic [5:0] req_w, req_h;
  logic [2:0] req_color;
  logic       req_mode;
  logic       pix_valid;
  logic       pix_ready;
  logic [9:0] pix_x, pix_y;
  logic [2:0] pix_color;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [22:0] got_q[$];
  logic [22:0] exp_q[$];
  int exp_positions;
  int first_valid_idx, done_idx, ready_idx, done_count;
  int stall_cycles, stall_err, hold_cycles;

  rect_draw_engine dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_w     (req_w),
    .req_h     (req_h),
    .req_color (req_color),
    .req_mode  (req_mode),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference: enumerate columns then rows, keep visited positions, drop off-screen ones.
  task automatic build_model(input int x, input int y, input int w, input int h,
                             input int c, input int mode);
    int px, py;
    exp_q.delete();
    exp_positions = 0;
    for (int i = 0; i < w; i++) begin
      for (int j = 0; j < h; j++) begin
        if (mode == 0 || i == 0 || i == w - 1 || j == 0 || j == h - 1) begin
          exp_positions++;
          px = x + i;
          py = y + j;
          if (px < 160 && py < 120) exp_q.push_back({px[9:0], py[9:0], c[2:0]});
        end
      end
    end
  endtask

  function automatic int seq_diffs();
    int d = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  // Issue one request and record what comes out; idx counts cycles after acceptance.
  // rmode: 0 = always ready, 1 = random ready, 2 = stall cycles 2..4
  task automatic run_req(input int x, input int y, input int w, input int h,
                         input int c, input int mode, input int rmode);
    int idx;
    logic [22:0] prev;
    bit prev_stall;
    got_q.delete();
    first_valid_idx = -1; done_idx = -1; ready_idx = -1; done_count = 0;
    stall_cycles = 0; stall_err = 0; hold_cycles = 0;
    idx = 0;
    while (!req_ready && idx < 100) begin
      @(negedge clk);
      idx++;
    end
    req_x = x[9:0]; req_y = y[9:0]; req_w = w[5:0]; req_h = h[5:0];
    req_color = c[2:0]; req_mode = mode[0]; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_x = 10'($urandom); req_y = 10'($urandom); req_w = 6'($urandom);
    req_h = 6'($urandom); req_color = 3'($urandom); req_mode = 1'($urandom);
    idx = 1;
    prev_stall = 1'b0;
    prev = '0;
    while (idx < 6000) begin
      if (pix_valid && first_valid_idx < 0) first_valid_idx = idx;
      if (prev_stall && (!pix_valid || {pix_x, pix_y, pix_color} !== prev)) stall_err++;
      if (pix_valid && pix_x == x[9:0] && pix_y == 10'(y + 1)) hold_cycles++;
      if (done) begin
        done_count++;
        if (done_idx < 0) done_idx = idx;
      end
      if (done_idx >= 0 && idx > done_idx && req_ready) begin
        ready_idx = idx;
        break;
      end
      case (rmode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ($urandom_range(0, 3) != 0);
        default: pix_ready = !(idx >= 2 && idx <= 4);
      endcase
      if (pix_valid && pix_ready) got_q.push_back({pix_x, pix_y, pix_color});
      if (pix_valid && !pix_ready) stall_cycles++;
      prev_stall = pix_valid && !pix_ready;
      prev = {pix_x, pix_y, pix_color};
      @(negedge clk);
      idx++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b valid=%b busy=%b done=%b want 1 0 0 0",
               req_ready, pix_valid, busy, done);
    end
    checks++;
    if (pix_x !== 10'd0 || pix_y !== 10'd0 || pix_color !== 3'd0) begin
      errors++;
      $display("FAIL reset_pix got x=%0d y=%0d c=%0d want 0 0 0", pix_x, pix_y, pix_color);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    build_model(10, 20, 3, 2, 5, 0);
    run_req(10, 20, 3, 2, 5, 0, 0);
    checks++;
    if (seq_diffs() !== 0) begin
      errors++;
      $display("FAIL fill_seq got %0d pixels want %0d, diffs %0d", got_q.size(), exp_q.size(), seq_diffs());
    end
    checks++;
    if (first_valid_idx !== 1) begin
      errors++;
      $display("FAIL fill_first_latency got %0d want 1", first_valid_idx);
    end
    checks++;
    if (done_idx !== 7 || done_count !== 1) begin
      errors++;
      $display("FAIL fill_done got idx %0d count %0d want 7 1", done_idx, done_count);
    end
    checks++;
    if (ready_idx !== 8) begin
      errors++;
      $display("FAIL fill_ready_again got %0d want 8", ready_idx);
    end
  endtask

  task automatic test_outline();
    build_model(0, 0, 4, 3, 6, 1);
    run_req(0, 0, 4, 3, 6, 1, 0);
    checks++;
    if (got_q.size() !== 10) begin
      errors++;
      $display("FAIL outline_count got %0d want 10", got_q.size());
    end
    checks++;
    if (seq_diffs() !== 0) begin
      errors++;
      $display("FAIL outline_seq diffs %0d", seq_diffs());
    end
    checks++;
    if (done_idx !== 11) begin
      errors++;
      $display("FAIL outline_done got %0d want 11", done_idx);
    end
  endtask

  task automatic test_backpressure();
    build_model(30, 40, 2, 2, 3, 0);
    run_req(30, 40, 2, 2, 3, 0, 2);
    checks++;
    if (hold_cycles !== 4) begin
      errors++;
      $display("FAIL bp_hold got %0d want 4", hold_cycles);
    end
    checks++;
    if (stall_err !== 0) begin
      errors++;
      $display("FAIL bp_stable got %0d unstable cycles want 0", stall_err);
    end
    checks++;
    if (got_q.size() !== 4 || seq_diffs() !== 0) begin
      errors++;
      $display("FAIL bp_seq got %0d pixels want 4, diffs %0d", got_q.size(), seq_diffs());
    end
    checks++;
    if (done_idx !== 8) begin
      errors++;
      $display("FAIL bp_done got %0d want 8", done_idx);
    end
  endtask

  task automatic test_clipping();
    build_model(158, 118, 4, 4, 1, 0);
    run_req(158, 118, 4, 4, 1, 0, 0);
    checks++;
    if (got_q.size() !== 4 || seq_diffs() !== 0) begin
      errors++;
      $display("FAIL clip_seq got %0d pixels want 4, diffs %0d", got_q.size(), seq_diffs());
    end
    checks++;
    if (done_idx !== 17) begin
      errors++;
      $display("FAIL clip_done got %0d want 17", done_idx);
    end
  endtask

  task automatic test_zero_size();
    run_req(5, 5, 0, 5, 2, 0, 0);
    checks++;
    if (first_valid_idx !== -1 || got_q.size() !== 0) begin
      errors++;
      $display("FAIL zero_no_pixels got first %0d count %0d want -1 0", first_valid_idx, got_q.size());
    end
    checks++;
    if (done_idx !== 1 || ready_idx !== 2) begin
      errors++;
      $display("FAIL zero_timing got done %0d ready %0d want 1 2", done_idx, ready_idx);
    end
  endtask

  task automatic test_reset_mid_draw();
    int seen_done = 0;
    req_x = 10'd5; req_y = 10'd5; req_w = 6'd3; req_h = 6'd3;
    req_color = 3'd2; req_mode = MODE_FILL; req_valid = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got valid=%b busy=%b ready=%b done=%b want 0 0 1 0",
               pix_valid, busy, req_ready, done);
    end
    repeat (6) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("FAIL midreset_no_done got %0d pulses want 0", seen_done);
    end
    build_model(70, 80, 1, 1, 7, 0);
    run_req(70, 80, 1, 1, 7, 0, 0);
    checks++;
    if (got_q.size() !== 1 || seq_diffs() !== 0) begin
      errors++;
      $display("FAIL midreset_next got %0d pixels want 1, diffs %0d", got_q.size(), seq_diffs());
    end
  endtask

  task automatic test_random();
    int x, y, w, h, c, m;
    for (int n = 0; n < 25; n++) begin
      x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 170));
      y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 130));
      w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 8));
      h = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 8));
      c = int'($urandom_range(0, 7));
      m = int'($urandom_range(0, 1));
      build_model(x, y, w, h, c, m);
      run_req(x, y, w, h, c, m, 1);
      checks++;
      if (seq_diffs() !== 0) begin
        errors++;
        $display("FAIL rand_seq[%0d] got %0d pixels want %0d, diffs %0d", n, got_q.size(), exp_q.size(), seq_diffs());
      end
      checks++;
      if (done_idx !== exp_positions + stall_cycles + 1 || done_count !== 1) begin
        errors++;
        $display("FAIL rand_done[%0d] got idx %0d count %0d want %0d 1", n, done_idx, done_count,
                 exp_positions + stall_cycles + 1);
      end
      checks++;
      if (ready_idx !== done_idx + 1 || stall_err !== 0) begin
        errors++;
        $display("FAIL rand_ready[%0d] got ready %0d unstable %0d want %0d 0", n, ready_idx, stall_err, done_idx + 1);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; pix_ready = 1'b1;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_color = '0; req_mode = 1'b0;
    test_reset();
    test_fill();
    test_outline();
    test_backpressure();
    test_clipping();
    test_zero_size();
    test_reset_mid_draw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_draw_engine.md
Name: rect_draw_engine

Overview:
- Parametrised rectangle rasteriser for the VGA pixel path.
- Accepts one rectangle request at a time (origin, size, colour, mode) over a valid/ready handshake.
- Emits one pixel per cycle over a back-pressurable valid/ready stream, in column-major order (y inner, x outer).
- Successor to the fixed-size brick drawer: variable size, fill/outline modes, screen clipping, output back-pressure and a completion pulse. Used by brick, paddle and ball drawing.

Parameters:
- COORD_W, 10, width of x/y coordinates.
- SIZE_W, 6, width of req_w/req_h; maximum size is 2^SIZE_W-1.
- COLOR_W, 3, pixel colour width.
- SCREEN_W, 160, pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, pixels with y >= SCREEN_H are clipped.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  engine can accept a request.
- req_x, req_y  in  COORD_W  top-left origin.
- req_w, req_h  in  SIZE_W  width and height in pixels.
- req_color  in  COLOR_W  pixel colour.
- req_mode  in  1  0 = fill, 1 = outline.
- pix_valid  out  1  pixel present.
- pix_ready  in  1  downstream accepts pixel.
- pix_x, pix_y  out  COORD_W  pixel coordinate.
- pix_color  out  COLOR_W  pixel colour.
- busy  out  1  request in progress (state != IDLE).
- done  out  1  one-cycle pulse after the last position is processed.

Behaviour:
- Reset (synchronous, active-high) forces IDLE.
  - Reset values: req_ready=1, pix_valid=0, busy=0, done=0.
  - pix_x, pix_y and pix_color reset to 0; col and row counters reset to 0.
- States:
  - IDLE: req_ready=1. On req_valid && req_ready, latch x0, y0, w, h, colour and mode; col=0, row=0.
    - If w==0 or h==0, go to DONE.
    - Otherwise go to DRAW.
  - DRAW: current position is (x0+col, y0+row).
  - DONE: done=1 for exactly one cycle, then IDLE. req_ready=0.
- Coordinate arithmetic: x0+col and y0+row are computed at COORD_W+1 bits.
  - A position is clipped if the sum is >= SCREEN_W (x) or >= SCREEN_H (y), or if the carry bit is set.
  - pix_x and pix_y are the low COORD_W bits of the sums.
- DRAW advance rules:
  - Unclipped position: pix_valid=1. Advance only on pix_ready.
  - While pix_valid && !pix_ready, pix_x, pix_y and pix_color stay stable.
  - Clipped position: pix_valid=0. Advance unconditionally after one cycle.
- Advance order:
  - If row is not the last row of the column: step row to the next row.
  - Otherwise: row=0 and col=col+1.
  - The last position is col==w-1 and row==h-1; advancing from it goes to DONE.
- Outline mode:
  - Columns col==0 and col==w-1 visit every row.
  - Interior columns visit row 0, then row h-1 only.
  - Every visited position costs exactly one (accepted or clipped) cycle.
  - Pixel count: 2w+2h-4 when w,h >= 2; w*h when w==1 or h==1.
- Fill mode pixel count: w*h.
- Latency:
  - Request accepted in cycle N gives first pix_valid in cycle N+1.
  - Last pixel accepted in cycle M gives done in cycle M+1 and req_ready in cycle M+2.
- req_valid during DRAW or DONE is ignored; the requester holds it.
- pix_ready is a don't-care when pix_valid=0.
- Reset mid-DRAW: the current request is abandoned, no done pulse, pix_valid=0 in the cycle after reset.
- Inputs are sampled only at acceptance; later changes on req_* have no effect.

Decomposition:
- Shared package: mode constants (MODE_FILL=0, MODE_OUTLINE=1), the COLOR_W default, and screen size constants (SCREEN_W, SCREEN_H).
- One sub-module, rect_scan_counter: holds col/row, takes w, h, mode and an advance strobe, and outputs col, row and a last flag, including the outline row skip.
- The top level holds the FSM, clipping, handshake and output mux.

Test Plan:
- Fill, x=10, y=20, w=3, h=2, colour 5, pix_ready always 1 -> pixels (10,20),(10,21),(11,20),(11,21),(12,20),(12,21), all colour 5, on consecutive cycles; done one cycle after (12,21).
- Outline, x=0, y=0, w=4, h=3 -> 10 pixels in order (0,0),(0,1),(0,2),(1,0),(1,2),(2,0),(2,2),(3,0),(3,1),(3,2); no interior pixel (1,1) or (2,1).
- Back-pressure: fill 2x2 with pix_ready low for 3 cycles on the second pixel -> (x0,y0+1) held stable for 4 cycles; no pixel lost or duplicated; exactly 4 accepted pixels.
- Clipping: fill x=158, y=118, w=4, h=4 -> only (158,118),(158,119),(159,118),(159,119) emitted; done after 16 position cycles total.
- Zero size: w=0, h=5 -> no pix_valid; done in cycle N+1; req_ready high again at N+2.
- Reset in DRAW after 2 pixels of a 3x3 fill -> pix_valid=0, busy=0, req_ready=1, no done; a new 1x1 request then emits exactly one pixel.
